icache_ctrl: RTL and testbench

- Direct-mapped instruction cache controller for the Cortex-M1 instruction fetch path.
- Sequences one 1024x32 simple-dual-port data RAM (synchronous read, 1-cycle latency, no output register) and one external tag RAM of the same type. Holds the valid bits in flops.
- On a miss, fills a 4-word line from the external memory port and returns the requested word to the CPU.

---
 rtl/icache_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_icache_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped, read-only instruction cache controller.
// Drives an external data RAM (one word per entry) and tag RAM (one tag per
// line). Both RAMs have a one-cycle synchronous read. Per-line valid bits are
// kept in flops. A miss fills the whole 4-word line in order, beats 0..3, and
// returns the requested word once the fill is done.
module icache_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 2,
  parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W - 2
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic                        cpu_req,
  input  logic [ADDR_W-1:0]           cpu_addr,
  output logic                        cpu_gnt,
  output logic                        cpu_rvalid,
  output logic [DATA_W-1:0]           cpu_rdata,
  output logic                        cpu_err,
  input  logic                        flush,
  output logic                        busy,
  output logic                        mem_req,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic                        mem_ack,
  input  logic                        mem_err,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        dram_wr_en,
  output logic [INDEX_W+OFFSET_W-1:0] dram_wr_addr,
  output logic [DATA_W-1:0]           dram_wr_data,
  output logic [INDEX_W+OFFSET_W-1:0] dram_rd_addr,
  input  logic [DATA_W-1:0]           dram_rd_data,
  output logic                        tag_wr_en,
  output logic [INDEX_W-1:0]          tag_wr_addr,
  output logic [TAG_W-1:0]            tag_wr_data,
  output logic [INDEX_W-1:0]          tag_rd_addr,
  input  logic [TAG_W-1:0]            tag_rd_data
);

  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_FILL   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [INDEX_W-1:0]  idx_q, idx_d;
  logic [OFFSET_W-1:0] off_q, off_d;
  logic [OFFSET_W-1:0] beat_q, beat_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic                err_q, err_d;
  logic                flush_seen_q, flush_seen_d;

  logic [TAG_W-1:0]    req_tag_s;
  logic [INDEX_W-1:0]  req_idx_s;
  logic [OFFSET_W-1:0] req_off_s;
  logic                hit_s;
  logic                miss_s;
  logic                gnt_s;
  logic                accept_s;
  logic                fill_ack_s;
  logic                err_ack_s;
  logic                last_ack_s;
  logic                unused_addr_bits;

  // Byte-lane bits of the fetch address carry no information for a word cache.
  assign unused_addr_bits = ^cpu_addr[1:0];

  assign req_tag_s = cpu_addr[ADDR_W-1 -: TAG_W];
  assign req_idx_s = cpu_addr[OFFSET_W+2 +: INDEX_W];
  assign req_off_s = cpu_addr[2 +: OFFSET_W];

  // Hit is judged on the valid bits as they stand before any flush this cycle.
  assign hit_s      = (state_q == ST_LOOKUP) && valid_q[idx_q] && (tag_rd_data == tag_q);
  assign miss_s     = (state_q == ST_LOOKUP) && !hit_s;
  assign gnt_s      = !flush && ((state_q == ST_IDLE) || hit_s);
  assign accept_s   = cpu_req && gnt_s;
  assign fill_ack_s = (state_q == ST_FILL) && mem_ack;
  assign err_ack_s  = fill_ack_s && mem_err;
  assign last_ack_s = fill_ack_s && !mem_err && (beat_q == {OFFSET_W{1'b1}});

  // State and datapath registers; reset aborts any fill and drops all lines.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= ST_IDLE;
      valid_q      <= '0;
      tag_q        <= '0;
      idx_q        <= '0;
      off_q        <= '0;
      beat_q       <= '0;
      word_q       <= '0;
      err_q        <= 1'b0;
      flush_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      idx_q        <= idx_d;
      off_q        <= off_d;
      beat_q       <= beat_d;
      word_q       <= word_d;
      err_q        <= err_d;
      flush_seen_q <= flush_seen_d;
    end
  end

  // Next-state logic for the lookup/fill sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) state_d = ST_LOOKUP;
        else          state_d = ST_IDLE;
      end
      ST_LOOKUP: begin
        if (hit_s) begin
          if (accept_s) state_d = ST_LOOKUP;
          else          state_d = ST_IDLE;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (err_ack_s || last_ack_s) state_d = ST_DONE;
        else                         state_d = ST_FILL;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture, valid-bit maintenance, beat counting and word capture.
  always_comb begin
    if (accept_s) begin
      tag_d = req_tag_s;
      idx_d = req_idx_s;
      off_d = req_off_s;
    end else begin
      tag_d = tag_q;
      idx_d = idx_q;
      off_d = off_q;
    end

    // A flush wipes every line; a miss drops the victim line before refill.
    if (flush) valid_d = '0;
    else       valid_d = valid_q;
    if (miss_s)          valid_d[idx_q] = 1'b0;
    else if (last_ack_s) valid_d[idx_q] = !(flush || flush_seen_q);
    else                 valid_d[idx_q] = valid_d[idx_q];

    if (miss_s)          beat_d = '0;
    else if (fill_ack_s) beat_d = beat_q + OFFSET_W'(1);
    else                 beat_d = beat_q;

    if (fill_ack_s && (beat_q == off_q)) word_d = mem_rdata;
    else                                 word_d = word_q;

    if (state_q == ST_DONE) err_d = 1'b0;
    else if (err_ack_s)     err_d = 1'b1;
    else                    err_d = err_q;

    if (state_q == ST_DONE)                   flush_seen_d = 1'b0;
    else if ((state_q == ST_FILL) && flush)   flush_seen_d = 1'b1;
    else                                      flush_seen_d = flush_seen_q;
  end

  // Output decode: CPU response, memory beat request and RAM write ports.
  always_comb begin
    cpu_gnt      = gnt_s;
    dram_rd_addr = {req_idx_s, req_off_s};
    tag_rd_addr  = req_idx_s;
    cpu_rvalid   = 1'b0;
    cpu_rdata    = '0;
    cpu_err      = 1'b0;
    busy         = 1'b0;
    mem_req      = 1'b0;
    mem_addr     = '0;
    dram_wr_en   = 1'b0;
    dram_wr_addr = '0;
    dram_wr_data = '0;
    tag_wr_en    = 1'b0;
    tag_wr_addr  = '0;
    tag_wr_data  = '0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_LOOKUP: begin
        if (hit_s) begin
          cpu_rvalid = 1'b1;
          cpu_rdata  = dram_rd_data;
        end else begin
          busy = 1'b1;
        end
      end
      ST_FILL: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {tag_q, idx_q, beat_q, 2'b00};
        // An errored beat carries no usable data, so it is not written.
        if (fill_ack_s && !mem_err) begin
          dram_wr_en   = 1'b1;
          dram_wr_addr = {idx_q, beat_q};
          dram_wr_data = mem_rdata;
        end else begin
          dram_wr_en   = 1'b0;
        end
        if (last_ack_s) begin
          tag_wr_en   = 1'b1;
          tag_wr_addr = idx_q;
          tag_wr_data = tag_q;
        end else begin
          tag_wr_en   = 1'b0;
        end
      end
      ST_DONE: begin
        busy       = 1'b1;
        cpu_rvalid = 1'b1;
        cpu_err    = err_q;
        if (err_q) cpu_rdata = '0;
        else       cpu_rdata = word_q;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: scenario tasks for icache_ctrl against a line-level
// cache model (valid/tag per index) and a synthetic backing memory.
module tb_icache_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_gnt, cpu_rvalid, cpu_err;
  logic [31:0] cpu_rdata;
  logic        flush, busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack, mem_err;
  logic [31:0] mem_rdata;
  logic        dram_wr_en;
  logic [9:0]  dram_wr_addr, dram_rd_addr;
  logic [31:0] dram_wr_data, dram_rd_data;
  logic        tag_wr_en;
  logic [7:0]  tag_wr_addr, tag_rd_addr;
  logic [19:0] tag_wr_data, tag_rd_data;

  always #5 HCLK = ~HCLK;

  icache_ctrl dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .flush(flush), .busy(busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_err(mem_err), .mem_rdata(mem_rdata),
    .dram_wr_en(dram_wr_en), .dram_wr_addr(dram_wr_addr), .dram_wr_data(dram_wr_data),
    .dram_rd_addr(dram_rd_addr), .dram_rd_data(dram_rd_data),
    .tag_wr_en(tag_wr_en), .tag_wr_addr(tag_wr_addr), .tag_wr_data(tag_wr_data),
    .tag_rd_addr(tag_rd_addr), .tag_rd_data(tag_rd_data)
  );

  // Simple-dual-port RAM models with one-cycle synchronous read.
  logic [31:0] dram [0:1023];
  logic [19:0] tram [0:255];
  always @(posedge HCLK) begin
    if (dram_wr_en) dram[dram_wr_addr] <= dram_wr_data;
    if (tag_wr_en)  tram[tag_wr_addr]  <= tag_wr_data;
    dram_rd_data <= dram[dram_rd_addr];
    tag_rd_data  <= tram[tag_rd_addr];
  end

  // Cache model: which line index currently holds which tag.
  bit          m_valid [256];
  logic [19:0] m_tag   [256];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16] + a[15:0] + 16'h1111};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge HCLK); #1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; cpu_req = 1'b0; cpu_addr = 32'h0; flush = 1'b0;
    mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(posedge HCLK);
    #2;
    n_checks++; if (cpu_gnt !== 1'b1)    $display("FAIL rst_gnt: got %b exp 1", cpu_gnt); else n_pass++;
    n_checks++; if (mem_req !== 1'b0)    $display("FAIL rst_mem_req: got %b exp 0", mem_req); else n_pass++;
    n_checks++; if (busy !== 1'b0)       $display("FAIL rst_busy: got %b exp 0", busy); else n_pass++;
    n_checks++; if (cpu_rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b exp 0", cpu_rvalid); else n_pass++;
    n_checks++; if ({cpu_err, dram_wr_en, tag_wr_en} !== 3'b000)
      $display("FAIL rst_misc: got %b exp 000", {cpu_err, dram_wr_en, tag_wr_en}); else n_pass++;
    n_checks++; if (mem_addr !== 32'h0)  $display("FAIL rst_mem_addr: got %h exp 0", mem_addr); else n_pass++;
    HRESETn = 1'b1;
    model_clear();
    tick();
    n_checks++; if (cpu_gnt !== 1'b1) $display("FAIL rst_gnt_release: got %b exp 1", cpu_gnt); else n_pass++;
  endtask

  // One fetch from IDLE; a miss is served beat by beat with optional fault injection.
  task automatic fetch(input logic [31:0] addr, input int err_beat, input int flush_beat,
                       input int rst_beat, input int max_delay);
    logic [7:0]  idx;
    logic [19:0] tag;
    logic [31:0] line, exp_word;
    bit          exp_hit, flushed, got_err;
    int          d;
    idx = addr[11:4]; tag = addr[31:12];
    line = {addr[31:4], 4'h0};
    exp_word = mem_word({addr[31:2], 2'b00});
    exp_hit = m_valid[idx] && (m_tag[idx] == tag);
    flushed = 1'b0; got_err = 1'b0;
    tick(); cpu_req = 1'b1; cpu_addr = addr; #1;
    n_checks++; if (cpu_gnt !== 1'b1) $display("FAIL accept_gnt %h: got %b exp 1", addr, cpu_gnt); else n_pass++;
    tick(); cpu_req = 1'b0; cpu_addr = $urandom; #1;
    n_checks++; if (cpu_rvalid !== exp_hit) $display("FAIL lookup_hit %h: got %b exp %b", addr, cpu_rvalid, exp_hit); else n_pass++;
    if (exp_hit) begin
      n_checks++; if (cpu_rdata !== exp_word) $display("FAIL hit_data %h: got %h exp %h", addr, cpu_rdata, exp_word); else n_pass++;
      n_checks++; if (mem_req !== 1'b0) $display("FAIL hit_mem_req %h: got %b exp 0", addr, mem_req); else n_pass++;
      return;
    end
    n_checks++; if (cpu_rdata !== 32'h0) $display("FAIL miss_rdata %h: got %h exp 0", addr, cpu_rdata); else n_pass++;
    m_valid[idx] = 1'b0;
    tick();
    for (int b = 0; b < 4; b++) begin
      d = $urandom_range(0, max_delay);
      for (int k = 0; k <= d; k++) begin
        if (k > 0) tick();
        n_checks++; if ({mem_req, busy, cpu_gnt} !== 3'b110)
          $display("FAIL fill_ctl b%0d: got %b exp 110", b, {mem_req, busy, cpu_gnt}); else n_pass++;
        n_checks++; if (mem_addr !== line + 32'(b * 4))
          $display("FAIL fill_addr b%0d: got %h exp %h", b, mem_addr, line + 32'(b * 4)); else n_pass++;
      end
      if (b == rst_beat) begin
        HRESETn = 1'b0; #1;
        n_checks++; if ({mem_req, busy} !== 2'b00) $display("FAIL rst_mid_fill: got %b exp 00", {mem_req, busy}); else n_pass++;
        tick(); HRESETn = 1'b1; #1;
        n_checks++; if (cpu_gnt !== 1'b1) $display("FAIL rst_mid_gnt: got %b exp 1", cpu_gnt); else n_pass++;
        model_clear();
        return;
      end
      mem_ack = 1'b1; mem_err = (b == err_beat); flush = (b == flush_beat);
      mem_rdata = mem_word(line + 32'(b * 4)); #1;
      if (!mem_err) begin
        n_checks++; if (dram_wr_en !== 1'b1 || dram_wr_addr !== {idx, 2'(b)} || dram_wr_data !== mem_rdata)
          $display("FAIL dram_wr b%0d: got %b/%h/%h exp 1/%h/%h", b, dram_wr_en, dram_wr_addr, dram_wr_data, {idx, 2'(b)}, mem_rdata);
        else n_pass++;
      end
      n_checks++; if (tag_wr_en !== (b == 3 && !mem_err))
        $display("FAIL tag_wr_en b%0d: got %b exp %b", b, tag_wr_en, (b == 3 && !mem_err)); else n_pass++;
      if (b == 3 && !mem_err) begin
        n_checks++; if (tag_wr_addr !== idx || tag_wr_data !== tag)
          $display("FAIL tag_wr: got %h/%h exp %h/%h", tag_wr_addr, tag_wr_data, idx, tag); else n_pass++;
      end
      if (flush) begin flushed = 1'b1; model_clear(); end
      if (mem_err) got_err = 1'b1;
      tick(); mem_ack = 1'b0; mem_err = 1'b0; flush = 1'b0; #1;
      if (got_err) break;
    end
    n_checks++; if (cpu_rvalid !== 1'b1 || cpu_err !== got_err)
      $display("FAIL done_flags %h: got %b%b exp 1%b", addr, cpu_rvalid, cpu_err, got_err); else n_pass++;
    n_checks++; if (cpu_rdata !== (got_err ? 32'h0 : exp_word))
      $display("FAIL done_data %h: got %h exp %h", addr, cpu_rdata, (got_err ? 32'h0 : exp_word)); else n_pass++;
    n_checks++; if ({busy, cpu_gnt, mem_req} !== 3'b100)
      $display("FAIL done_ctl %h: got %b exp 100", addr, {busy, cpu_gnt, mem_req}); else n_pass++;
    if (!got_err && !flushed) begin m_valid[idx] = 1'b1; m_tag[idx] = tag; end
    tick(); #1;
    n_checks++; if ({busy, cpu_rvalid} !== 2'b00) $display("FAIL idle_after %h: got %b exp 00", addr, {busy, cpu_rvalid}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [3];
    bit exp_hit;
    a[0] = 32'h100; a[1] = 32'h108; a[2] = 32'h10C;
    tick(); cpu_req = 1'b1; cpu_addr = a[0]; #1;
    n_checks++; if (cpu_gnt !== 1'b1) $display("FAIL b2b_gnt0: got %b exp 1", cpu_gnt); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      exp_hit = m_valid[a[i][11:4]] && (m_tag[a[i][11:4]] == a[i][31:12]);
      tick();
      if (i < 2) cpu_addr = a[i+1]; else cpu_req = 1'b0;
      #1;
      n_checks++; if (cpu_rvalid !== exp_hit) $display("FAIL b2b_rvalid%0d: got %b exp %b", i, cpu_rvalid, exp_hit); else n_pass++;
      n_checks++; if (cpu_rdata !== mem_word(a[i])) $display("FAIL b2b_data%0d: got %h exp %h", i, cpu_rdata, mem_word(a[i])); else n_pass++;
      n_checks++; if ({mem_req, cpu_gnt} !== 2'b01) $display("FAIL b2b_ctl%0d: got %b exp 01", i, {mem_req, cpu_gnt}); else n_pass++;
    end
    tick(); #1;
    n_checks++; if (cpu_rvalid !== 1'b0) $display("FAIL b2b_end: got %b exp 0", cpu_rvalid); else n_pass++;
  endtask

  task automatic test_flush_lookup();
    flush = 1'b1; #1;
    n_checks++; if (cpu_gnt !== 1'b0) $display("FAIL flush_gnt: got %b exp 0", cpu_gnt); else n_pass++;
    tick(); flush = 1'b0; model_clear(); #1;
    n_checks++; if (cpu_gnt !== 1'b1) $display("FAIL flush_gnt_rel: got %b exp 1", cpu_gnt); else n_pass++;
    fetch(32'h0000_0100, -1, -1, -1, 0);
    tick(); cpu_req = 1'b1; cpu_addr = 32'h0000_0100; #1;
    tick(); cpu_req = 1'b0; flush = 1'b1; #1;
    n_checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== mem_word(32'h100))
      $display("FAIL flush_hit: got %b/%h exp 1/%h", cpu_rvalid, cpu_rdata, mem_word(32'h100)); else n_pass++;
    n_checks++; if (cpu_gnt !== 1'b0) $display("FAIL flush_hit_gnt: got %b exp 0", cpu_gnt); else n_pass++;
    tick(); flush = 1'b0; model_clear(); #1;
    fetch(32'h0000_0100, -1, -1, -1, 1);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    int eb;
    for (int n = 0; n < 24; n++) begin
      addr = {18'h0, 2'($urandom_range(0, 3)), 4'h2, 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      eb = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1;
      fetch(addr, eb, -1, -1, 2);
    end
  endtask

  initial begin
    test_reset();
    fetch(32'h0000_0104, -1, -1, -1, 0);
    test_back_to_back();
    fetch(32'h0000_1104, -1, -1, -1, 1);
    fetch(32'h0000_0104, -1, -1, -1, 1);
    fetch(32'h0000_2000, -1, 2, -1, 1);
    fetch(32'h0000_2000, -1, -1, -1, 1);
    fetch(32'h0000_0300, 2, -1, -1, 1);
    fetch(32'h0000_0300, -1, -1, -1, 1);
    fetch(32'h0000_0500, -1, -1, 1, 1);
    fetch(32'h0000_0500, -1, -1, -1, 1);
    test_flush_lookup();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
